ime_fisher_accum: RTL and testbench
===================================

Name: ime_fisher_accum

Overview:
- Receiving end of the Fisher term stream produced by the IME core stage's Fisher datapath.
- Consumes per-element Fisher terms, each with its last and poison flags.
- Sums the terms of one packet (sequence terminated by last) into a wide sum.
- Emits one result beat per packet, carrying sum, term count and status flags, toward the core/writeback.
- Poison-aware valid/ready handshake on both sides.

Parameters:
W_ACC, 32, width of incoming Fisher term (unsigned)
W_SUM, 48, width of packet sum; must be >= W_ACC
K_MAX, 4096, maximum terms per packet
W_CNT, $clog2(K_MAX+1), width of term counter (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  term valid
in_ready  out  1  term accepted when in_valid&&in_ready
in_fisher_term  in  W_ACC  unsigned Fisher term
in_last  in  1  final term of packet
in_poison  in  1  term poisoned
flush  in  1  synchronous discard of partial packet
out_valid  out  1  packet result valid
out_ready  in  1  result consumed when out_valid&&out_ready
out_fisher_sum  out  W_SUM  packet sum (saturating)
out_count  out  W_CNT  terms accepted in packet
out_poison  out  1  any term poisoned
out_overflow  out  1  sum saturated
out_len_error  out  1  packet closed at K_MAX without last

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high, sampled on posedge clk.
- Reset (also mid-packet or mid-hold) values: state=ACC, accumulators and flags cleared, out_valid=0, out_fisher_sum=0, out_count=0, out_poison=0, out_overflow=0, out_len_error=0. in_ready=1 from the first cycle after reset deasserts.
- FSM has two states.
  - ACC: in_ready = !flush.
  - OUT: in_ready=0, out_valid=1.
- Accepted beat in ACC:
  - count <= count+1.
  - poison_acc |= in_poison.
  - If in_poison=0: sum <= sum + zero-extended term, computed at W_SUM+1 bits.
  - If the carry bit is set: sum <= all-ones and ovf_acc <= 1; once set, sum stays all-ones for the rest of the packet.
  - A poisoned term adds 0 but is still counted.
- Packet close: on an accepted beat with in_last=1, or with count+1==K_MAX and in_last=0 (the latter sets len_err).
  - On close, the next cycle is OUT, and the output registers hold the final values including the closing beat.
  - Latency: out_valid asserts exactly 1 cycle after the closing beat is accepted.
  - After a K_MAX close, following upstream beats start a new packet.
- OUT:
  - All outputs are held stable while out_ready=0.
  - On out_valid&&out_ready: next cycle state is ACC, accumulators and flags are cleared, and out_valid=0.
  - Minimum one-cycle bubble between packets: in_ready=0 on the handshake cycle.
- flush:
  - In ACC: partial packet discarded (accumulators cleared), no output produced, and an in_valid beat in the same cycle is not accepted.
  - In OUT: ignored; the pending result is not dropped.
- Single-beat packet (in_last on first beat): count=1, sum=term.
- Outputs are registered; there are no combinational paths from in_* to out_*. in_ready depends only on state and flush.

Test Plan:
- Terms 10,20,30,40 on consecutive cycles, last on 40 -> 1 cycle later out_valid=1, sum=100, count=4, poison=0, overflow=0, len_error=0.
- Same packet with out_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout; handshake on cycle 6 -> out_valid=0 next cycle, then next packet 7 (last) -> sum=7, count=1.
- Terms 5, 9 (poison), 3, last -> sum=8, count=3, poison=1; following packet 2 (last) -> poison=0, sum=2.
- W_ACC=8, W_SUM=9: terms 255,255,255, last -> sum=511, overflow=1, count=3.
- K_MAX=4: 5 beats of 1, none last -> result after 4th beat: sum=4, count=4, len_error=1; 5th beat opens new packet.
- Terms 3,4 then flush (in_valid=1 with term 100 on flush cycle) -> no out_valid, term 100 not accepted; then 6 (last) -> sum=6, count=1. Repeat with rst asserted mid-packet -> same outcome, all outputs 0 during reset.

Source files
------------

// File: rtl/ime_fisher_accum.sv
// Fisher term packet accumulator: sums the terms of one packet with saturation
// and emits a single result beat carrying the sum, the term count and status flags.
module ime_fisher_accum #(
    parameter int unsigned W_ACC = 32,
    parameter int unsigned W_SUM = 48,
    parameter int unsigned K_MAX = 4096,
    localparam int unsigned W_CNT = $clog2(K_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_ACC-1:0] in_fisher_term,
    input  logic             in_last,
    input  logic             in_poison,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_SUM-1:0] out_fisher_sum,
    output logic [W_CNT-1:0] out_count,
    output logic             out_poison,
    output logic             out_overflow,
    output logic             out_len_error
);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t           state_q;
    logic             out_valid_q;
    logic [W_SUM-1:0] sum_q;
    logic [W_CNT-1:0] count_q;
    logic             poison_q;
    logic             ovf_q;
    logic             len_err_q;

    logic [W_SUM:0]   sum_ext;
    logic [W_CNT-1:0] cnt_inc;
    logic             at_kmax;
    logic             accept;

    always_comb begin
        sum_ext = {1'b0, sum_q} + {{(W_SUM + 1 - W_ACC){1'b0}}, in_fisher_term};
        cnt_inc = count_q + W_CNT'(1);
        at_kmax = (cnt_inc == W_CNT'(K_MAX));
        accept  = in_valid && in_ready;
    end

    assign in_ready = (state_q == ACC) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACC;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            count_q     <= '0;
            poison_q    <= 1'b0;
            ovf_q       <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ACC: begin
                    if (flush) begin
                        sum_q     <= '0;
                        count_q   <= '0;
                        poison_q  <= 1'b0;
                        ovf_q     <= 1'b0;
                        len_err_q <= 1'b0;
                    end else if (accept) begin
                        count_q  <= cnt_inc;
                        poison_q <= poison_q | in_poison;
                        // Saturation is sticky: all-ones is held once the carry has been seen.
                        if (!in_poison) begin
                            if (ovf_q || sum_ext[W_SUM]) begin
                                sum_q <= '1;
                                ovf_q <= 1'b1;
                            end else begin
                                sum_q <= sum_ext[W_SUM-1:0];
                            end
                        end
                        if (in_last || at_kmax) begin
                            state_q     <= OUT;
                            out_valid_q <= 1'b1;
                            len_err_q   <= !in_last;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= ACC;
                        out_valid_q <= 1'b0;
                        sum_q       <= '0;
                        count_q     <= '0;
                        poison_q    <= 1'b0;
                        ovf_q       <= 1'b0;
                        len_err_q   <= 1'b0;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

    assign out_valid      = out_valid_q;
    assign out_fisher_sum = sum_q;
    assign out_count      = count_q;
    assign out_poison     = poison_q;
    assign out_overflow   = ovf_q;
    assign out_len_error  = len_err_q;

endmodule

// File: tb/tb_ime_fisher_accum.sv
// Directed bench for ime_fisher_accum: default-width instance driven from a vector
// table, plus a narrow instance for saturation and K_MAX closing.
module tb_ime_fisher_accum;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        m_valid, m_ready, m_last, m_poison, m_flush, m_oready, m_ovalid;
    logic [31:0] m_term;
    logic [47:0] m_sum;
    logic [12:0] m_cnt;
    logic        m_opz, m_ovf, m_le;

    // narrow instance: W_ACC=8, W_SUM=9, K_MAX=4
    logic        s_valid, s_ready, s_last, s_poison, s_flush, s_oready, s_ovalid;
    logic [7:0]  s_term;
    logic [8:0]  s_sum;
    logic [2:0]  s_cnt;
    logic        s_opz, s_ovf, s_le;

    ime_fisher_accum u_dut (
        .clk(clk), .rst(rst),
        .in_valid(m_valid), .in_ready(m_ready), .in_fisher_term(m_term),
        .in_last(m_last), .in_poison(m_poison), .flush(m_flush),
        .out_valid(m_ovalid), .out_ready(m_oready), .out_fisher_sum(m_sum),
        .out_count(m_cnt), .out_poison(m_opz), .out_overflow(m_ovf),
        .out_len_error(m_le)
    );

    ime_fisher_accum #(.W_ACC(8), .W_SUM(9), .K_MAX(4)) u_small (
        .clk(clk), .rst(rst),
        .in_valid(s_valid), .in_ready(s_ready), .in_fisher_term(s_term),
        .in_last(s_last), .in_poison(s_poison), .flush(s_flush),
        .out_valid(s_ovalid), .out_ready(s_oready), .out_fisher_sum(s_sum),
        .out_count(s_cnt), .out_poison(s_opz), .out_overflow(s_ovf),
        .out_len_error(s_le)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v;
        logic [31:0] t;
        logic        l, p, f, r;
        logic        eov, eir;
        logic [47:0] esum;
        logic [12:0] ecnt;
        logic        epz, eovf, ele;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic v, input logic [31:0] t, input logic l,
                                input logic p, input logic f, input logic r,
                                input logic eov, input logic eir, input logic [47:0] esum,
                                input logic [12:0] ecnt, input logic epz,
                                input logic eovf, input logic ele);
        vec_t x;
        x.v = v; x.t = t; x.l = l; x.p = p; x.f = f; x.r = r;
        x.eov = eov; x.eir = eir; x.esum = esum; x.ecnt = ecnt;
        x.epz = epz; x.eovf = eovf; x.ele = ele;
        return x;
    endfunction

    task automatic chk_main(input string tag, input logic [47:0] sum, input logic [12:0] cnt,
                            input logic pz, input logic ovf, input logic le);
        chk({tag, " sum"}, 64'(m_sum), 64'(sum));
        chk({tag, " count"}, 64'(m_cnt), 64'(cnt));
        chk({tag, " poison"}, 64'(m_opz), 64'(pz));
        chk({tag, " overflow"}, 64'(m_ovf), 64'(ovf));
        chk({tag, " len_error"}, 64'(m_le), 64'(le));
    endtask

    task automatic chk_small(input string tag, input logic [8:0] sum, input logic [2:0] cnt,
                             input logic ovf, input logic le);
        chk({tag, " out_valid"}, 64'(s_ovalid), 64'd1);
        chk({tag, " sum"}, 64'(s_sum), 64'(sum));
        chk({tag, " count"}, 64'(s_cnt), 64'(cnt));
        chk({tag, " poison"}, 64'(s_opz), 64'd0);
        chk({tag, " overflow"}, 64'(s_ovf), 64'(ovf));
        chk({tag, " len_error"}, 64'(s_le), 64'(le));
    endtask

    task automatic sbeat(input logic v, input logic [7:0] t, input logic l, input logic r);
        @(negedge clk);
        s_valid = v; s_term = t; s_last = l; s_oready = r;
    endtask

    initial begin
        rst = 1'b1;
        m_valid = 0; m_term = '0; m_last = 0; m_poison = 0; m_flush = 0; m_oready = 0;
        s_valid = 0; s_term = '0; s_last = 0; s_poison = 0; s_flush = 0; s_oready = 0;

        //          v  term l  p  f  r   ov ir sum  cnt pz ovf le
        tv.push_back(mk(1, 10, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 20, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 30, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 40, 1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 100, 4, 0, 0, 0));
        tv.push_back(mk(1, 10, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 20, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 30, 0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 40, 1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 100, 4, 0, 0, 0));
        // beat offered on the handshake cycle must be refused
        tv.push_back(mk(1, 99, 1, 0, 0, 1,  1, 0, 100, 4, 0, 0, 0));
        tv.push_back(mk(1, 7,  1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 7,   1, 0, 0, 0));
        tv.push_back(mk(1, 5,  0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 9,  0, 1, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 3,  1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 8,   3, 1, 0, 0));
        tv.push_back(mk(1, 2,  1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 2,   1, 0, 0, 0));
        tv.push_back(mk(1, 3,  0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 4,  0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 100,0, 0, 1, 0,  0, 0, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 6,  1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 6,   1, 0, 0, 0));
        // flush while holding a result is ignored
        tv.push_back(mk(1, 1,  1, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));
        tv.push_back(mk(1, 50, 1, 0, 1, 0,  1, 0, 1,   1, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 1,  1, 0, 1,   1, 0, 0, 0));
        tv.push_back(mk(0, 0,  0, 0, 0, 0,  0, 1, 0,   0, 0, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset m out_valid", 64'(m_ovalid), 64'd0);
        chk_main("reset m", 0, 0, 0, 0, 0);
        chk("reset s out_valid", 64'(s_ovalid), 64'd0);
        chk("reset s sum", 64'(s_sum), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-reset m in_ready", 64'(m_ready), 64'd1);
        chk("post-reset s in_ready", 64'(s_ready), 64'd1);

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            m_valid = tv[i].v; m_term = tv[i].t; m_last = tv[i].l;
            m_poison = tv[i].p; m_flush = tv[i].f; m_oready = tv[i].r;
            #1;
            chk($sformatf("vec%0d out_valid", i), 64'(m_ovalid), 64'(tv[i].eov));
            chk($sformatf("vec%0d in_ready", i), 64'(m_ready), 64'(tv[i].eir));
            if (tv[i].eov)
                chk_main($sformatf("vec%0d", i), tv[i].esum, tv[i].ecnt,
                         tv[i].epz, tv[i].eovf, tv[i].ele);
        end

        // reset mid-packet with a beat offered during reset
        @(negedge clk); m_valid = 1; m_term = 3; m_last = 0; m_poison = 0; m_flush = 0; m_oready = 0;
        @(negedge clk); m_term = 4;
        @(negedge clk); rst = 1; m_term = 100;
        @(posedge clk); #1;
        chk("rst-mid out_valid", 64'(m_ovalid), 64'd0);
        chk_main("rst-mid", 0, 0, 0, 0, 0);
        @(negedge clk); rst = 0; m_term = 6; m_last = 1;
        @(negedge clk); m_valid = 0; m_last = 0; m_oready = 1;
        #1;
        chk("rst-mid after out_valid", 64'(m_ovalid), 64'd1);
        chk_main("rst-mid after", 6, 1, 0, 0, 0);

        // reset while a result is held
        @(negedge clk); m_oready = 0; m_valid = 1; m_term = 9; m_last = 1;
        @(negedge clk); m_valid = 0; m_last = 0;
        #1;
        chk("hold out_valid", 64'(m_ovalid), 64'd1);
        chk("hold sum", 64'(m_sum), 64'd9);
        rst = 1;
        @(posedge clk); #1;
        chk("rst-hold out_valid", 64'(m_ovalid), 64'd0);
        chk_main("rst-hold", 0, 0, 0, 0, 0);
        @(negedge clk); rst = 0;
        #1;
        chk("rst-hold in_ready", 64'(m_ready), 64'd1);

        // saturation on the narrow instance: 255*3 exceeds 511
        sbeat(1, 255, 0, 0);
        sbeat(1, 255, 0, 0);
        sbeat(1, 255, 1, 0);
        sbeat(0, 0, 0, 0);
        #1;
        chk_small("ovf", 511, 3, 1, 0);
        sbeat(0, 0, 0, 1);
        sbeat(0, 0, 0, 0);
        #1;
        chk("ovf cleared out_valid", 64'(s_ovalid), 64'd0);
        chk("ovf cleared in_ready", 64'(s_ready), 64'd1);

        // K_MAX close without last, then a new packet
        for (int i = 0; i < 4; i++) sbeat(1, 1, 0, 0);
        sbeat(1, 1, 1, 0);
        #1;
        chk_small("kmax", 4, 4, 0, 1);
        chk("kmax in_ready", 64'(s_ready), 64'd0);
        sbeat(1, 1, 1, 1);
        sbeat(1, 1, 1, 0);
        #1;
        chk("kmax next in_ready", 64'(s_ready), 64'd1);
        sbeat(0, 0, 0, 0);
        #1;
        chk_small("kmax next", 1, 1, 0, 0);
        sbeat(0, 0, 0, 1);
        sbeat(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
